tag_store_nway: RTL and testbench



---
 rtl/tag_store_nway.sv | 219 +++++++++++++++++++++
 tb/tb_tag_store_nway.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_store_nway.sv
// N-way set-associative tag store: valid bits, tree pseudo-LRU victim choice and a
// sequenced invalidate-all sweep. Lookups resolve at the accepting edge; results are registered.
module tag_store_nway #(
    parameter int INDEX_BITS = 10,
    parameter int TAG_BITS   = 36,
    parameter int WAYS       = 4
) (
    input  logic                       clk,
    input  logic                       gen_reset,
    input  logic                       lookup_valid,
    output logic                       lookup_ready,
    input  logic [INDEX_BITS-1:0]      lookup_index,
    input  logic [TAG_BITS-1:0]        lookup_tag,
    output logic                       res_valid,
    output logic                       res_hit,
    output logic                       res_multi_hit,
    output logic [$clog2(WAYS)-1:0]    res_way,
    output logic [$clog2(WAYS)-1:0]    res_victim_way,
    output logic                       res_victim_valid,
    output logic [TAG_BITS-1:0]        res_victim_tag,
    input  logic                       fill_valid,
    input  logic [INDEX_BITS-1:0]      fill_index,
    input  logic [$clog2(WAYS)-1:0]    fill_way,
    input  logic [TAG_BITS-1:0]        fill_tag,
    input  logic                       inv_all_req,
    output logic                       inv_busy
);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int TREE_BITS = WAYS - 1;

    typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [INDEX_BITS-1:0]   sweep_cnt_reg, sweep_cnt_next;

    logic [WAYS-1:0]         valid_mem [SETS];
    logic [TREE_BITS-1:0]    plru_mem  [SETS];

    logic [TAG_BITS-1:0]     lk_tag [WAYS];
    logic [WAYS-1:0]         lk_valid;
    logic [WAYS-1:0]         lk_match;
    logic [TREE_BITS-1:0]    lk_plru;
    logic [WAYS-1:0]         hit_oh;
    logic [WAYS-1:0]         free_oh;
    logic [WAY_BITS-1:0]     hit_enc  [WAYS+1];
    logic [WAY_BITS-1:0]     free_enc [WAYS+1];
    logic                    lk_hit;
    logic                    lk_multi;
    logic                    lk_full;
    logic [WAY_BITS-1:0]     hit_way;
    logic [WAY_BITS-1:0]     victim_way;
    logic                    lookup_fire;
    logic                    fill_en;
    logic [TREE_BITS-1:0]    hit_plru;
    logic [TREE_BITS-1:0]    fill_base;
    logic [TREE_BITS-1:0]    fill_plru;

    logic                    res_valid_reg;
    logic                    res_hit_reg;
    logic                    res_multi_reg;
    logic [WAY_BITS-1:0]     res_way_reg;
    logic [WAY_BITS-1:0]     res_vway_reg;
    logic                    res_vvalid_reg;
    logic [TAG_BITS-1:0]     res_vtag_reg;

    // Tree nodes are heap-ordered (root = node 0); a node bit of 1 points at its upper half.
    function automatic logic [TREE_BITS-1:0] plru_touch(input logic [TREE_BITS-1:0] bits,
                                                        input logic [WAY_BITS-1:0] way);
        logic [TREE_BITS-1:0] r;
        logic [TREE_BITS-1:0] mask;
        logic [WAY_BITS-1:0]  way_sh;
        int                   node;
        r = bits;
        for (int l = 0; l < WAY_BITS; l++) begin
            node   = (1 << l) - 1 + int'(way >> (WAY_BITS - l));
            mask   = TREE_BITS'(1) << node;
            way_sh = way >> (WAY_BITS - 1 - l);
            r      = way_sh[0] ? (r & ~mask) : (r | mask);
        end
        return r;
    endfunction

    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [TREE_BITS-1:0] bits);
        logic [WAY_BITS-1:0]  v;
        logic [TREE_BITS-1:0] t;
        int                   node;
        v    = '0;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            t    = bits >> node;
            v    = (v << 1) | WAY_BITS'(t[0]);
            node = 2 * node + 1 + int'(t[0]);
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            state_reg     <= SWEEP;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            SWEEP: begin
                sweep_cnt_next = sweep_cnt_reg + 1'b1;
                if (sweep_cnt_reg == {INDEX_BITS{1'b1}}) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (inv_all_req) begin
                    state_next     = SWEEP;
                    sweep_cnt_next = '0;
                end
            end
            default: begin
                state_next     = SWEEP;
                sweep_cnt_next = '0;
            end
        endcase
    end

    assign lookup_ready = (state_reg == RUN);
    assign inv_busy     = (state_reg == SWEEP);
    assign lookup_fire  = lookup_valid && (state_reg == RUN);
    assign fill_en      = fill_valid && (state_reg == RUN);

    assign lk_valid = valid_mem[lookup_index];
    assign lk_plru  = plru_mem[lookup_index];

    assign hit_enc[0]  = '0;
    assign free_enc[0] = '0;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_BITS-1:0] tag_mem [SETS];

            always_ff @(posedge clk) begin
                if (fill_en && (fill_way == WAY_BITS'(gi))) begin
                    tag_mem[fill_index] <= fill_tag;
                end
            end

            assign lk_tag[gi]       = tag_mem[lookup_index];
            assign lk_match[gi]     = lk_valid[gi] && (lk_tag[gi] == lookup_tag);
            assign hit_enc[gi + 1]  = hit_enc[gi]  | (hit_oh[gi]  ? WAY_BITS'(gi) : '0);
            assign free_enc[gi + 1] = free_enc[gi] | (free_oh[gi] ? WAY_BITS'(gi) : '0);
        end
    endgenerate

    // Isolate the lowest matching way and the lowest empty way as one-hot vectors.
    assign hit_oh     = lk_match & (~lk_match + WAYS'(1));
    assign free_oh    = ~lk_valid & (lk_valid + WAYS'(1));
    assign lk_hit     = |lk_match;
    assign lk_multi   = |(lk_match & (lk_match - WAYS'(1)));
    assign lk_full    = &lk_valid;
    assign hit_way    = hit_enc[WAYS];
    assign victim_way = lk_full ? plru_victim(lk_plru) : free_enc[WAYS];

    // A same-set fill builds on the hit-updated tree so its bits win where paths overlap.
    assign hit_plru  = plru_touch(lk_plru, hit_way);
    assign fill_base = (lookup_fire && lk_hit && (lookup_index == fill_index)) ? hit_plru
                                                                              : plru_mem[fill_index];
    assign fill_plru = plru_touch(fill_base, fill_way);

    always_ff @(posedge clk) begin
        if (state_reg == SWEEP) begin
            valid_mem[sweep_cnt_reg] <= '0;
            plru_mem[sweep_cnt_reg]  <= '0;
        end else begin
            if (lookup_fire && lk_hit) begin
                plru_mem[lookup_index] <= hit_plru;
            end
            if (fill_en) begin
                valid_mem[fill_index][fill_way] <= 1'b1;
                plru_mem[fill_index]            <= fill_plru;
            end
        end
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            res_valid_reg  <= 1'b0;
            res_hit_reg    <= 1'b0;
            res_multi_reg  <= 1'b0;
            res_way_reg    <= '0;
            res_vway_reg   <= '0;
            res_vvalid_reg <= 1'b0;
            res_vtag_reg   <= '0;
        end else begin
            res_valid_reg <= lookup_fire;
            if (lookup_fire) begin
                res_hit_reg    <= lk_hit;
                res_multi_reg  <= lk_multi;
                res_way_reg    <= hit_way;
                res_vway_reg   <= victim_way;
                res_vvalid_reg <= lk_full;
                res_vtag_reg   <= lk_tag[victim_way];
            end
        end
    end

    assign res_valid        = res_valid_reg;
    assign res_hit          = res_hit_reg;
    assign res_multi_hit    = res_multi_reg;
    assign res_way          = res_way_reg;
    assign res_victim_way   = res_vway_reg;
    assign res_victim_valid = res_vvalid_reg;
    assign res_victim_tag   = res_vtag_reg;

endmodule

// File: tb/tb_tag_store_nway.sv
// Self-checking bench for tag_store_nway: directed scenarios plus randomized traffic
// checked against a per-set behavioural model (valid/tag tables and a level-indexed PLRU tree).
module tb_tag_store_nway;
    localparam int IB   = 10;
    localparam int TB   = 36;
    localparam int W    = 4;
    localparam int L    = 2;
    localparam int SETS = 1024;

    logic          clk = 1'b0;
    logic          gen_reset;
    logic          lookup_valid;
    logic          lookup_ready;
    logic [IB-1:0] lookup_index;
    logic [TB-1:0] lookup_tag;
    logic          res_valid;
    logic          res_hit;
    logic          res_multi_hit;
    logic [1:0]    res_way;
    logic [1:0]    res_victim_way;
    logic          res_victim_valid;
    logic [TB-1:0] res_victim_tag;
    logic          fill_valid;
    logic [IB-1:0] fill_index;
    logic [1:0]    fill_way;
    logic [TB-1:0] fill_tag;
    logic          inv_all_req;
    logic          inv_busy;

    tag_store_nway #(.INDEX_BITS(IB), .TAG_BITS(TB), .WAYS(W)) dut (
        .clk(clk), .gen_reset(gen_reset),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_index(lookup_index), .lookup_tag(lookup_tag),
        .res_valid(res_valid), .res_hit(res_hit), .res_multi_hit(res_multi_hit),
        .res_way(res_way), .res_victim_way(res_victim_way),
        .res_victim_valid(res_victim_valid), .res_victim_tag(res_victim_tag),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .fill_tag(fill_tag), .inv_all_req(inv_all_req), .inv_busy(inv_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: tree bit per (level, node-within-level); 1 means victim lies in the upper half.
    bit            m_valid [SETS][W];
    logic [TB-1:0] m_tag   [SETS][W];
    bit            m_tree  [SETS][L][W/2];
    bit            m_run;
    int            sweep_left;

    logic          e_valid, e_hit, e_multi, e_vvalid;
    logic [1:0]    e_way, e_vway;
    logic [TB-1:0] e_vtag;

    function automatic logic [7:0] exp_vec();
        return {e_valid, e_hit, e_multi, e_way, e_vway, e_vvalid};
    endfunction

    function automatic logic [7:0] got_vec();
        return {res_valid, res_hit, res_multi_hit, res_way, res_victim_way, res_victim_valid};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
            for (int l = 0; l < L; l++)
                for (int p = 0; p < W/2; p++) m_tree[s][l][p] = 1'b0;
        end
    endtask

    task automatic model_touch(input int idx, input int way);
        for (int l = 0; l < L; l++)
            m_tree[idx][l][way >> (L - l)] = (((way >> (L - 1 - l)) & 1) == 0);
    endtask

    // Drives one cycle, predicts its result from the model, advances one edge, samples at +1.
    task automatic do_cycle(input bit lv, input int li, input logic [TB-1:0] lt,
                            input bit fv, input int fi, input int fw, input logic [TB-1:0] ft,
                            input bit inv);
        bit acc;
        int hits;
        int p;
        lookup_valid = lv;  lookup_index = li[IB-1:0];  lookup_tag = lt;
        fill_valid   = fv;  fill_index   = fi[IB-1:0];  fill_way   = fw[1:0];  fill_tag = ft;
        inv_all_req  = inv;
        acc     = lv && m_run;
        e_valid = acc;
        if (acc) begin
            hits = 0;  e_way = 2'd0;
            for (int w = 0; w < W; w++) begin
                if (m_valid[li][w] && m_tag[li][w] === lt) begin
                    if (hits == 0) e_way = 2'(w);
                    hits++;
                end
            end
            e_hit   = (hits > 0);
            e_multi = (hits > 1);
            e_vvalid = 1'b1;  e_vway = 2'd0;
            for (int w = W - 1; w >= 0; w--) begin
                if (!m_valid[li][w]) begin e_vvalid = 1'b0;  e_vway = 2'(w); end
            end
            if (e_vvalid) begin
                p = 0;
                for (int l = 0; l < L; l++) p = p * 2 + int'(m_tree[li][l][p]);
                e_vway = 2'(p);
            end
            e_vtag = m_tag[li][e_vway];
            if (e_hit) model_touch(li, e_way);
        end
        if (fv && m_run) begin
            m_valid[fi][fw] = 1'b1;
            m_tag[fi][fw]   = ft;
            model_touch(fi, fw);
        end
        if (!m_run) begin
            sweep_left--;
            if (sweep_left == 0) m_run = 1'b1;
        end else if (inv) begin
            model_clear();
            m_run = 1'b0;
            sweep_left = SETS;
        end
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;  fill_valid = 1'b0;  inv_all_req = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        int busy;
        gen_reset = 1'b1;
        #2;
        n_checks++;
        if ({lookup_ready, got_vec(), inv_busy} !== 10'b0_0000_0000_1)
            $display("FAIL %s_reset_outputs: got %b required %b", tag,
                     {lookup_ready, got_vec(), inv_busy}, 10'b0_0000_0000_1);
        else n_pass++;
        n_checks++;
        if (res_victim_tag !== '0)
            $display("FAIL %s_reset_vtag: got %h required 0", tag, res_victim_tag);
        else n_pass++;
        @(posedge clk);
        #1;
        gen_reset = 1'b0;
        model_clear();
        m_run = 1'b0;  sweep_left = SETS;
        {e_valid, e_hit, e_multi, e_way, e_vway, e_vvalid} = '0;
        e_vtag = '0;
        busy = 0;
        for (int i = 0; i < SETS; i++) begin
            if (inv_busy === 1'b1 && lookup_ready === 1'b0) busy++;
            do_cycle(1'b0, 0, '0, 1'b0, 0, 0, '0, 1'b0);
        end
        n_checks++;
        if (busy != SETS || inv_busy !== 1'b0 || lookup_ready !== 1'b1)
            $display("FAIL %s_sweep_len: busy cycles %0d ready %b, required %0d then ready 1",
                     tag, busy, lookup_ready, SETS);
        else n_pass++;
    endtask

    task automatic test_first_lookup();
        do_cycle(1'b1, 5, 36'h123, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_valid, res_hit, res_victim_way, res_victim_valid} !== 5'b1_0_00_0)
            $display("FAIL first_lookup: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_fill_hit();
        do_cycle(1'b0, 0, '0, 1'b1, 5, 2, 36'hABC, 1'b0);
        n_checks++;
        if (res_valid !== 1'b0)
            $display("FAIL fill_no_result: got res_valid %b required 0", res_valid);
        else n_pass++;
        do_cycle(1'b1, 5, 36'hABC, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_way} !== 3'b1_10)
            $display("FAIL fill_hit: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
        do_cycle(1'b1, 5, 36'hABD, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_victim_way} !== 3'b0_00)
            $display("FAIL fill_miss: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_plru();
        for (int w = 0; w < W; w++) do_cycle(1'b0, 0, '0, 1'b1, 7, w, 36'h700 + w, 1'b0);
        do_cycle(1'b1, 7, 36'h7FF, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_victim_way, res_victim_valid} !== 3'b00_1 || res_victim_tag !== 36'h700)
            $display("FAIL plru_full_victim: got %b tag %h required %b tag %h",
                     got_vec(), res_victim_tag, exp_vec(), e_vtag);
        else n_pass++;
        do_cycle(1'b1, 7, 36'h700, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_way} !== 3'b1_00)
            $display("FAIL plru_hit_way0: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
        do_cycle(1'b1, 7, 36'h7FF, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || res_victim_way !== 2'd2 || res_victim_tag !== 36'h702)
            $display("FAIL plru_after_hit: got %b tag %h required %b tag %h",
                     got_vec(), res_victim_tag, exp_vec(), e_vtag);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        do_cycle(1'b1, 9, 36'h55, 1'b1, 9, 1, 36'h55, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || res_hit !== 1'b0)
            $display("FAIL rbw_same_edge: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
        do_cycle(1'b1, 9, 36'h55, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_way} !== 3'b1_01)
            $display("FAIL rbw_next: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_inv_all();
        int busy;
        int quiet;
        do_cycle(1'b0, 0, '0, 1'b1, 3, 0, 36'h333, 1'b0);
        do_cycle(1'b1, 3, 36'h333, 1'b1, 1023, 3, 36'h3FF, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || res_hit !== 1'b1)
            $display("FAIL inv_prefill_hit: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
        do_cycle(1'b0, 0, '0, 1'b0, 0, 0, '0, 1'b1);
        busy = 0;  quiet = 0;
        for (int i = 0; i < SETS; i++) begin
            if (inv_busy === 1'b1 && lookup_ready === 1'b0) busy++;
            do_cycle(1'b1, 3, 36'h333, 1'b1, 3, i % W, 36'h333, 1'b0);
            if (res_valid === 1'b0) quiet++;
        end
        n_checks++;
        if (busy != SETS || quiet != SETS || inv_busy !== 1'b0)
            $display("FAIL inv_sweep: busy %0d quiet %0d, required %0d each", busy, quiet, SETS);
        else n_pass++;
        do_cycle(1'b1, 3, 36'h333, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_victim_way, res_victim_valid} !== 4'b0_00_0)
            $display("FAIL inv_idx3_miss: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
        do_cycle(1'b1, 1023, 36'h3FF, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_victim_way, res_victim_valid} !== 4'b0_00_0)
            $display("FAIL inv_idx1023_miss: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int held;
        do_cycle(1'b0, 0, '0, 1'b1, 6, 3, 36'h66, 1'b0);
        do_cycle(1'b1, 6, 36'h66, 1'b0, 0, 0, '0, 1'b1);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_way, inv_busy} !== 4'b1_11_1)
            $display("FAIL sweep_start_lookup: got %b busy %b required %b busy 1",
                     got_vec(), inv_busy, exp_vec());
        else n_pass++;
        held = 0;
        for (int i = 0; i < 500; i++) begin
            do_cycle(1'b1, 6, 36'h66, 1'b0, 0, 0, '0, 1'b0);
            if (got_vec() === exp_vec() && res_hit === 1'b1) held++;
        end
        n_checks++;
        if (held != 500)
            $display("FAIL sweep_hold: held %0d cycles required 500", held);
        else n_pass++;
        test_reset("mid_sweep");
    endtask

    task automatic test_multi_hit();
        do_cycle(1'b0, 0, '0, 1'b1, 4, 1, 36'h44, 1'b0);
        do_cycle(1'b0, 0, '0, 1'b1, 4, 3, 36'h44, 1'b0);
        do_cycle(1'b1, 4, 36'h44, 1'b0, 0, 0, '0, 1'b0);
        n_checks++;
        if (got_vec() !== exp_vec() || {res_hit, res_multi_hit, res_way} !== 4'b1_1_01)
            $display("FAIL multi_hit: got %b required %b", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pool [4] = '{0, 1, 2, 1023};
        int li, fi;
        bit lv, fv;
        for (int i = 0; i < 800; i++) begin
            lv = ($urandom_range(0, 3) != 0);
            fv = ($urandom_range(0, 1) != 0);
            li = pool[$urandom_range(0, 3)];
            fi = pool[$urandom_range(0, 3)];
            do_cycle(lv, li, 36'h100 + 36'($urandom_range(0, 5)),
                     fv, fi, $urandom_range(0, W - 1), 36'h100 + 36'($urandom_range(0, 5)), 1'b0);
            n_checks++;
            if (got_vec() !== exp_vec() || (e_vvalid && res_victim_tag !== e_vtag))
                $display("FAIL random_%0d: got %b tag %h required %b tag %h",
                         i, got_vec(), res_victim_tag, exp_vec(), e_vtag);
            else n_pass++;
        end
    endtask

    initial begin
        gen_reset    = 1'b1;
        lookup_valid = 1'b0;  lookup_index = '0;  lookup_tag = '0;
        fill_valid   = 1'b0;  fill_index   = '0;  fill_way   = '0;  fill_tag = '0;
        inv_all_req  = 1'b0;
        m_run = 1'b0;  sweep_left = SETS;
        repeat (3) @(posedge clk);
        #1;
        test_reset("power_on");
        test_first_lookup();
        test_fill_hit();
        test_plru();
        test_read_before_write();
        test_inv_all();
        test_reset_mid_sweep();
        test_multi_hit();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
